// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a TX FIFO, a runtime baud
// divisor, compile-time parity/stop-bit selection and a four-word register window.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | line idle (tx=1), waiting for enable and a queued byte
// ST_START   | start bit (tx=0) for one latched bit period
// ST_DATA    | eight data bits, LSB first, one bit period each
// ST_PARITY  | parity bit (even or odd); never entered when PARITY=0
// ST_STOP    | STOP_BITS stop bits (tx=1); may chain straight into ST_START
//
// Register window (word offsets from BASE_ADDR):
//   +0 STATUS  [0] not_full [1] empty [2] busy [3] overflow [15:8] count
//   +1 DATA    write pushes wdata[7:0]; reads 0
//   +2 DIV     bit period in clocks, minimum 4
//   +3 CTRL    [0] enable, [1] clear_overflow (W1), [2] flush (W1)

module uart_tx_mmio #(
    parameter int unsigned BASE_ADDR   = 12'h800,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 434,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [15:0]       bus_wdata,
    input  logic              bus_we,
    output logic [15:0]       bus_rdata,
    output logic              bus_hit,
    output logic              irq_tx_empty,
    output logic              tx
);

    localparam int unsigned       PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       DIV_RST    = 16'(DEFAULT_DIV);
    localparam logic [15:0]       DIV_MIN    = 16'd4;
    localparam logic              HAS_PARITY = (PARITY != 0);
    localparam logic              PAR_ODD    = (PARITY == 2);
    localparam logic              LAST_STOP  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_off;
    logic              win_hit;
    logic [1:0]        reg_sel;
    logic              wr_data;
    logic              wr_div;
    logic              wr_ctrl;

    // Offsets below the base wrap to large values, so one compare covers both sides.
    assign addr_off = bus_addr - BASE_A;
    assign win_hit  = (addr_off < ADDR_W'(4));
    assign reg_sel  = addr_off[1:0];
    assign wr_data  = bus_we && win_hit && (reg_sel == 2'd1);
    assign wr_div   = bus_we && win_hit && (reg_sel == 2'd2);
    assign wr_ctrl  = bus_we && win_hit && (reg_sel == 2'd3);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [15:0] div_q;
    logic        enable_q;
    logic        overflow_q;
    logic        flush;
    logic        ovf_clr;
    logic        ovf_set;

    assign flush   = wr_ctrl && bus_wdata[2];
    assign ovf_clr = wr_ctrl && bus_wdata[1];

    // Divisor, enable and sticky overflow; a same-cycle overflow beats the clear.
    always_ff @(posedge clock) begin
        if (rst) begin
            div_q      <= DIV_RST;
            enable_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_div) begin
                div_q <= (bus_wdata < DIV_MIN) ? DIV_MIN : bus_wdata;
            end
            if (wr_ctrl) begin
                enable_q <= bus_wdata[0];
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;
    logic [7:0]       head_byte;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged on the pre-edge count, so a same-cycle pop cannot rescue a full push.
    assign push_ok    = wr_data && !fifo_full && !flush;
    assign ovf_set    = wr_data && fifo_full && !flush;
    assign head_byte  = mem[rd_ptr_q];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus_wdata[7:0];
        end
    end

    // Pointers and occupancy; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_n;
    logic [15:0] tick_q;
    logic [15:0] frame_div_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_n;
    logic        par_q;
    logic        tx_q;
    logic        tx_n;
    logic        tick_tc;
    logic        last_bit;
    logic        frame_end;

    assign tick_tc   = (tick_q == 16'd0);
    assign last_bit  = (bit_idx_q == 3'd7);
    assign frame_end = (state_q == ST_STOP) && tick_tc && (stop_idx_q == LAST_STOP);
    // A pop happens from idle, or on the last stop edge so frames chain without a gap.
    assign pop       = enable_q && !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    // State register and registered line driver; reset forces the line idle immediately.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            tx_q    <= tx_n;
        end
    end

    // Next-state decode driven by the bit-period terminal count.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) state_n = ST_START;
            end
            ST_START: begin
                if (tick_tc) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (tick_tc && last_bit) state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (tick_tc) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (frame_end) state_n = pop ? ST_START : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output decode: next shift value and the line level for the coming state.
    always_comb begin
        shreg_n = shreg_q;
        if (pop) begin
            shreg_n = head_byte;
        end else if ((state_q == ST_DATA) && tick_tc) begin
            shreg_n = {1'b0, shreg_q[7:1]};
        end
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
            ST_PARITY: tx_n = par_q;
            default:   tx_n = 1'b1;
        endcase
    end

    // Frame datapath: bit-period down-counter, bit/stop indices, shifter, parity.
    always_ff @(posedge clock) begin
        if (rst) begin
            tick_q      <= 16'd0;
            frame_div_q <= DIV_RST;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            shreg_q     <= 8'd0;
            par_q       <= 1'b0;
        end else begin
            shreg_q <= shreg_n;
            if (pop) begin
                // The divisor is frozen per frame so DIV writes only affect later frames.
                frame_div_q <= div_q;
                tick_q      <= div_q - 16'd1;
                bit_idx_q   <= 3'd0;
                stop_idx_q  <= 1'b0;
                par_q       <= (^head_byte) ^ PAR_ODD;
            end else if (state_q != ST_IDLE) begin
                if (tick_tc) begin
                    tick_q <= frame_div_q - 16'd1;
                    if (state_q == ST_DATA) bit_idx_q <= bit_idx_q + 3'd1;
                    if (state_q == ST_STOP) stop_idx_q <= stop_idx_q + 1'b1;
                end else begin
                    tick_q <= tick_q - 16'd1;
                end
            end
        end
    end

    assign tx           = tx_q;
    assign irq_tx_empty = fifo_empty && (state_q == ST_IDLE) && enable_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0]  count_b;
    logic [15:0] status_w;
    logic [15:0] rd_mux;

    assign count_b  = 8'(count_q);
    assign status_w = {count_b, 4'b0000, overflow_q, (state_q != ST_IDLE), fifo_empty, !fifo_full};

    // Register read mux; self-clearing CTRL bits always read back as zero.
    always_comb begin
        rd_mux = 16'd0;
        case (reg_sel)
            2'd0:    rd_mux = status_w;
            2'd2:    rd_mux = div_q;
            2'd3:    rd_mux = {15'd0, enable_q};
            default: rd_mux = 16'd0;
        endcase
    end

    // One-cycle read latency matching the data RAM; misses return zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            bus_rdata <= 16'd0;
            bus_hit   <= 1'b0;
        end else begin
            bus_hit   <= win_hit;
            bus_rdata <= win_hit ? rd_mux : 16'd0;
        end
    end

endmodule
